result_buffer: RTL
==================

# result_buffer

Downstream stage of the series-evaluation datapath: captures each 10-bit `result` when the controller signals completion and holds it in a small FIFO. Results are presented to the consumer on a valid/ready interface. The buffer decouples the datapath from a slow consumer. It raises `full` so the controller can hold off the next computation, and it latches a sticky overflow flag if a result arrives with no free slot.

## Interface
- `W`, 10, data width; matches the datapath `result` width.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous and active-high; clears all state.
- `in_valid`  input  1  one-cycle pulse from the controller; `in_data` is final.
- `in_data`  input  W  datapath `result`.
- `out_valid`  output  1  head entry available.
- `out_data`  output  W  head entry; meaningful only when `out_valid`=1.
- `out_ready`  input  1  consumer accepts the head entry this cycle.
- `full`  output  1  count == DEPTH.
- `count`  output  $clog2(DEPTH+1)  number of stored entries.
- `overflow`  output  1  sticky; a result was dropped.
- `clr_ovf`  input  1  synchronous clear of `overflow`.

## Operation
- Storage is DEPTH×W registers, with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits and wrapping modulo DEPTH.
- `count` is held in its own register.
- Pop is `out_valid & out_ready`: `rp` increments and `count` decrements.
- Push is `in_valid & (~full | pop)`: `mem[wp]` ← `in_data`, `wp` increments, `count` increments.
- Simultaneous push and pop: both pointers advance and `count` is unchanged.
  - When full, the pop frees the slot in the same cycle, so the push is accepted and nothing is dropped.
- Push when empty: `out_valid` is 0, so no pop can occur that cycle. The entry is written and becomes visible the next cycle. There is no bypass.
- Drop is `in_valid & full & ~pop`.
  - No state changes except `overflow` ← 1.
  - The stored data is untouched.
- `overflow` update:
  - `clr_ovf` alone clears it.
  - `clr_ovf` together with a drop in the same cycle leaves `overflow` = 1, because set has priority.
- `out_data` = `mem[rp]`, a combinational read of the register array.
- `out_valid` = (`count` != 0).
- `full` = (`count` == DEPTH).
- `out_ready` while `out_valid`=0 has no effect.
- `in_valid` held high for several cycles is treated as several pushes. The controller guarantees single-cycle pulses.
- No arithmetic is applied to the data; it passes through bit-exact.

## Timing
- Reset values: `wp`=`rp`=0, `count`=0, `out_valid`=0, `full`=0, `overflow`=0, `out_data`=`mem[0]`.
  - Memory contents are don't-care after reset, but the bench expects 0.
- Reset mid-operation discards all entries immediately, since reset is asynchronous.
  - An `in_valid` in the reset-release cycle is accepted only if `rst` has deasserted before that clock edge.
- Push latency: `in_valid` sampled at edge N → `out_valid`=1 and `out_data` valid after edge N.
- Pop: the consumer samples `out_data` in the same cycle it asserts `out_ready`. The next entry appears after that edge.
- `full` and `count` update on the edge of the push or pop; they are registered-derived with no combinational path from inputs.
- `out_valid` does not depend combinationally on `in_valid` or `out_ready`.
- Sustained throughput is one push plus one pop per cycle.

## Test plan
- Reset, then push 0x155 → next cycle `out_valid`=1, `out_data`=0x155, `count`=1; pop → `count`=0, `out_valid`=0.
- Push 0x001, 0x002, 0x003, 0x004 with `out_ready`=0 → `full`=1, `count`=4. Then push 0x3FF → `overflow`=1, `count`=4, and popping returns 0x001..0x004 in order.
- Full FIFO, push 0x2AA and pop in the same cycle → no overflow, `count` stays 4, and 0x2AA is returned last.
- Ten push/pop pairs interleaved so `wp` and `rp` wrap twice → data order preserved, `count` never exceeds 4.
- `overflow`=1, assert `clr_ovf` alone → cleared. Then assert `clr_ovf` together with a drop → `overflow` remains 1.
- Three entries stored, assert `rst` asynchronously mid-cycle → `out_valid`, `count`, `full` and `overflow` are 0 immediately, before the next edge.

Source files
------------

// File: rtl/result_buffer.sv
// Result FIFO between the series-evaluation datapath and a slow consumer.
// Captures each completed result, presents it on valid/ready, and flags dropped results.
module result_buffer #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [W-1:0]                 in_data,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  input  logic                         out_ready,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic pop_c;
  logic push_c;
  logic drop_c;

  // Handshake decode; a pop on a full buffer frees the slot for a same-cycle push.
  always_comb begin
    pop_c  = out_valid & out_ready;
    push_c = in_valid & (~full | pop_c);
    drop_c = in_valid & full & ~pop_c;
  end

  // Next-state for pointers, occupancy, storage and the sticky overflow flag.
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (push_c) begin
      mem_d[wp_q] = in_data;
      wp_d        = AW'(wp_q + AW'(1));
    end
    if (pop_c) begin
      rp_d = AW'(rp_q + AW'(1));
    end
    if (push_c && !pop_c) begin
      count_d = CW'(count_q + CW'(1));
    end else if (pop_c && !push_c) begin
      count_d = CW'(count_q - CW'(1));
    end

    // A drop wins over a same-cycle clear so the loss is never hidden.
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // All status outputs derive from registers only.
  always_comb begin
    out_data  = mem_q[rp_q];
    out_valid = (count_q != '0);
    full      = (count_q == CW'(DEPTH));
    count     = count_q;
    overflow  = ovf_q;
  end

endmodule
